// File: rtl/uart_rx_if.sv
// Byte-side handshake bundle for the UART receiver: data/valid/ready plus error pulses.
// The master side is the receiver; the slave side is the consuming fabric.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    output data,
    output valid,
    output frame_err,
    output parity_err,
    output overrun,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    input  frame_err,
    input  parity_err,
    input  overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver with 2-of-3 majority sampling and a valid/ready byte port.
// Optional parity checking is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int OVERSAMPLING = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic      clk,
  input  logic      resetn,
  input  logic      baud_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] SMP0     = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] SMP1     = CW'(OVERSAMPLING / 2);
  localparam logic [CW-1:0] SMP2     = CW'(OVERSAMPLING / 2 + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_smp;
  logic                 r_rx_meta;
  logic                 r_rx_s;

  state_t               w_state_next;
  logic [CW-1:0]        w_cnt_next;
  logic [BW-1:0]        w_bitcnt_next;
  logic [DATA_BITS-1:0] w_shift_next;
  logic [2:0]           w_smp_next;
  logic                 w_maj;
  logic                 w_stop;
  logic                 w_deliver;
  logic                 w_ferr;

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic w_par_bad_next;
  logic w_perr;
`endif

  assign w_maj  = maj3(r_smp[0], r_smp[1], r_smp[2]);
  // The stop decision happens on the third sample tick, so the live sample stands in for r_smp[2].
  assign w_stop = maj3(r_smp[0], r_smp[1], r_rx_s);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_smp     <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bitcnt  <= w_bitcnt_next;
      r_shift   <= w_shift_next;
      r_smp     <= w_smp_next;
`ifdef UART_RX_PARITY_EN
      r_par_bad <= w_par_bad_next;
`endif
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_bitcnt_next = r_bitcnt;
    w_shift_next  = r_shift;
    w_smp_next    = r_smp;
    w_deliver     = 1'b0;
    w_ferr        = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_next = r_par_bad;
    w_perr         = 1'b0;
`endif

    if (baud_tick) begin
      if (r_state != S_IDLE && r_state != S_BREAK) begin
        w_cnt_next = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);
        if (r_cnt == SMP0) w_smp_next[0] = r_rx_s;
        if (r_cnt == SMP1) w_smp_next[1] = r_rx_s;
        if (r_cnt == SMP2) w_smp_next[2] = r_rx_s;
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            w_state_next = S_START;
            w_cnt_next   = CW'(1);
`ifdef UART_RX_PARITY_EN
            w_par_bad_next = 1'b0;
`endif
          end
        end
        S_START: begin
          if (r_cnt == CNT_LAST) begin
            w_bitcnt_next = '0;
            w_state_next  = w_maj ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (r_cnt == CNT_LAST) begin
            w_shift_next = {w_maj, r_shift[DATA_BITS-1:1]};
            if (r_bitcnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              w_state_next = S_PARITY;
`else
              w_state_next = S_STOP;
`endif
            end else begin
              w_bitcnt_next = r_bitcnt + BW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == CNT_LAST) begin
            w_par_bad_next = w_maj != ((^r_shift) ^ PARITY_ODD[0]);
            w_state_next   = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == SMP2) begin
            w_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
            if (w_stop) begin
              w_state_next = S_IDLE;
              w_deliver    = !r_par_bad;
              w_perr       = r_par_bad;
            end else begin
              w_state_next = S_BREAK;
              w_ferr       = 1'b1;
              w_perr       = r_par_bad;
            end
`else
            if (w_stop) begin
              w_state_next = S_IDLE;
              w_deliver    = 1'b1;
            end else begin
              w_state_next = S_BREAK;
              w_ferr       = 1'b1;
            end
`endif
          end
        end
        S_BREAK: begin
          if (r_rx_s) w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // A byte arriving while the previous one is still unaccepted is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bus.data       <= '0;
      bus.valid      <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err <= w_ferr;
      bus.overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bus.parity_err <= w_perr;
`else
      bus.parity_err <= 1'b0;
`endif
      if (w_deliver) begin
        if (!bus.valid || bus.ready) begin
          bus.data  <= r_shift;
          bus.valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that sits directly downstream of the baud tick generator. It consumes the generator's `baud*OVERSAMPLING` tick pulse to sample an asynchronous serial line. It recovers 8N1 frames, LSB first, and presents each byte on a valid/ready interface to the fabric. It flags framing errors, overruns and, optionally, parity errors.

## Interface
- `OVERSAMPLING`, 8: ticks per bit; must equal the tick generator's `oversampling`; legal values are even and ≥4.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd; used only with the parity macro.

Ports:
- `clk`  input  1  system clock, single clock domain.
- `resetn`  input  1  synchronous, active-low reset.
- `baud_tick`  input  1  one-`clk` pulse at `baud*OVERSAMPLING` from the tick generator.
- `rx`  input  1  asynchronous serial line; idle high.
- `data`  output  DATA_BITS  received byte; valid while `valid`=1.
- `valid`  output  1  byte available.
- `ready`  input  1  consumer accepts the byte when `valid`&&`ready`.
- `frame_err`  output  1  one-cycle pulse: stop bit sampled 0.
- `parity_err`  output  1  one-cycle pulse: parity mismatch. Tied 0 without the macro.
- `overrun`  output  1  one-cycle pulse: completed byte dropped because `valid` was held.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`). Both flops reset to 1.
- All bit-timing logic advances only on cycles with `baud_tick`=1. The handshake logic runs every cycle.
- Tick counter `cnt` runs 0..OVERSAMPLING-1 within each bit window.
- Samples are taken at `cnt` = OS/2-1, OS/2 and OS/2+1. The bit value is the 2-of-3 majority.
- States and transitions:
  - IDLE: on a tick with `rx_s`=0, go to START with `cnt`=1; that tick counts as tick 0.
  - START: at `cnt`=OS-1, a majority of 1 means a false start, so return to IDLE with no error. A majority of 0 goes to DATA.
  - DATA: shift the majority into a shift register LSB first. After DATA_BITS windows go to PARITY (macro) or STOP.
  - PARITY: check the sampled bit against XOR(data)^PARITY_ODD, then go to STOP.
  - STOP: decide at `cnt`=OS/2+1 rather than at window end, to allow back-to-back frames.
    - Stop=1 with parity OK: deliver the byte and go to IDLE.
    - Stop=1 with parity bad: pulse `parity_err`, discard the byte, go to IDLE.
    - Stop=0: pulse `frame_err` (and `parity_err` if parity also failed), discard the byte, go to BREAK.
  - BREAK: wait for a tick with `rx_s`=1, then go to IDLE. A held-low line therefore produces exactly one `frame_err`.
- Delivery rules:
  - `valid`=0: load `data`, set `valid`.
  - `valid`=1 and `ready`=1 in the same cycle: load the new byte, keep `valid`=1.
  - `valid`=1 and `ready`=0: keep the old byte, pulse `overrun`.
- `valid` clears on the clock after `valid`&&`ready` unless a new byte loads in that cycle.
- `data` is stable while `valid`=1 and not accepted.

## Timing
- Reset values: `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0. State is IDLE, `cnt`=0, synchronizer =1.
- Reset mid-frame abandons the frame immediately, with no error pulses.
- `rx` to `rx_s` latency is 2 clocks.
- Start detection jitter is ≤1 tick plus 2 clocks.
- `valid`, `frame_err`, `parity_err` and `overrun` assert on the clock edge following the STOP-decision tick cycle. The pulses are exactly one `clk` wide.
- Frame completes (OS/2+2) ticks into the stop bit, so the next start edge is always caught.
- `baud_tick` asserted on consecutive clocks is legal; each high cycle counts as one tick.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state is compiled in; frames are start + DATA_BITS + parity + stop.
  - `parity_err` is driven as specified above.
- Undefined:
  - No PARITY state; frames are start + DATA_BITS + stop.
  - `parity_err` is constant 0.
  - `PARITY_ODD` is ignored.

## Test plan
Common setup: OVERSAMPLING=8, DATA_BITS=8, `baud_tick` every 13 clocks, bit period 104 clocks.

1. Send 0xA5 with `ready`=1. Required: `data`=0xA5 with `valid` high for one cycle, and all error outputs 0.
2. Drive `rx` low for 2 ticks, then high. Required: no `valid`, no error pulse, and a following 0x3C is received correctly.
3. Send 0x3C with stop bit 0, then hold `rx` low for 20 bit times, release, and send 0x55. Required: exactly one `frame_err` pulse, no `valid` for 0x3C, then `data`=0x55.
4. Send 0x11 and 0x22 back-to-back with `ready`=0. Required: `data` stays 0x11 and `overrun` pulses once. Then raise `ready` for one cycle: 0x11 is accepted and `valid` drops.
5. Macro on, even parity:
   - 0x07 with parity bit 1: required `data`=0x07.
   - 0x07 with parity bit 0: required a `parity_err` pulse and no `valid`.
6. Pulse `resetn`=0 for one clock during data bit 4, then send 0xF0. Required: `valid`=0 after reset, no error pulses, then `data`=0xF0.
